// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory responder (slave).
// Valid/ready handshake on both the request and the response channel.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: word-addressed 16-bit array answering one load/store at a time
// after LATENCY wait states, with the response held until the MEM stage takes it.
module data_mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  count;
  logic        cap_write;
  logic [15:0] cap_addr;
  logic [15:0] cap_wdata;
  logic [15:0] rdata_q;
  logic        error_q;
  logic        accept;
  logic        access;
  logic        in_range;
  logic [AW-1:0] index;

  logic [15:0] mem [DEPTH];

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;

  assign accept   = (state == IDLE) && bus.req_valid;
  assign access   = (state == BUSY) && (count == 4'd0);
  assign in_range = 32'(cap_addr) < 32'(DEPTH);
  assign index    = cap_addr[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.req_valid) state_next = BUSY;
      BUSY:    if (count == 4'd0) state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Captured request, wait counter and registered response; the response regs
  // only change when the access is performed, so they stay stable through RESP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cap_write <= 1'b0;
      cap_addr  <= 16'h0000;
      cap_wdata <= 16'h0000;
      count     <= 4'd0;
      rdata_q   <= 16'h0000;
      error_q   <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        count     <= 4'(LATENCY - 1);
      end else if ((state == BUSY) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end

      if (access) begin
        if (in_range) begin
          rdata_q <= cap_write ? cap_wdata : mem[index];
          error_q <= 1'b0;
        end else begin
          rdata_q <= 16'h0000;
          error_q <= 1'b1;
        end
      end
    end
  end

  // Array contents survive reset; an async reset forces IDLE, so a pending store never lands.
  always_ff @(posedge clk) begin
    if (access && in_range && cap_write) begin
      mem[index] <= cap_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at LATENCY=2 and one at LATENCY=1,
// directed scenarios plus random traffic checked against an array-based reference model.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT2  = 2;
  localparam int LAT1  = 1;

  typedef struct packed {
    logic        req_ready;
    logic        rsp_valid;
    logic        rsp_error;
    logic [15:0] rsp_rdata;
  } obs_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;

  // Reference memory per instance: index 0 is the LATENCY=2 unit, index 1 the LATENCY=1 unit.
  logic [15:0] model [2][DEPTH];

  always #5 clk = ~clk;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus1 ();

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  task automatic check_output(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v, input logic w,
                       input logic [15:0] a, input logic [15:0] d, input logic rr);
    if (sel) begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = a;
      bus1.req_wdata = d; bus1.rsp_ready = rr;
    end else begin
      bus2.req_valid = v; bus2.req_write = w; bus2.req_addr = a;
      bus2.req_wdata = d; bus2.rsp_ready = rr;
    end
  endtask

  function automatic obs_t sample(input bit sel);
    obs_t o;
    if (sel) o = '{bus1.req_ready, bus1.rsp_valid, bus1.rsp_error, bus1.rsp_rdata};
    else     o = '{bus2.req_ready, bus2.rsp_valid, bus2.rsp_error, bus2.rsp_rdata};
    return o;
  endfunction

  // One complete transaction; the response is refused for 'hold' cycles before being taken.
  task automatic apply_stimulus(input bit sel, input logic wr, input logic [15:0] addr,
                                input logic [15:0] wdata, input int hold);
    int          lat;
    logic [15:0] exp_data;
    logic        exp_err;
    obs_t        o;
    lat = sel ? LAT1 : LAT2;
    if (int'(addr) >= DEPTH) begin
      exp_data = 16'h0000;
      exp_err  = 1'b1;
    end else begin
      exp_err = 1'b0;
      if (wr) begin
        model[sel][int'(addr)] = wdata;
        exp_data = wdata;
      end else begin
        exp_data = model[sel][int'(addr)];
      end
    end

    @(negedge clk);
    drive(sel, 1'b1, wr, addr, wdata, hold == 0);
    o = sample(sel);
    check_bit("req_ready_before_accept", o.req_ready, 1'b1);

    @(negedge clk);
    drive(sel, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom), hold == 0);
    o = sample(sel);
    check_bit("req_ready_after_accept", o.req_ready, 1'b0);
    check_bit("rsp_valid_early", o.rsp_valid, 1'b0);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      o = sample(sel);
      check_bit("rsp_valid_wait", o.rsp_valid, 1'b0);
    end

    @(negedge clk);
    o = sample(sel);
    check_bit("rsp_valid_on_time", o.rsp_valid, 1'b1);
    check_output("rsp_rdata", o.rsp_rdata, exp_data);
    check_bit("rsp_error", o.rsp_error, exp_err);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      o = sample(sel);
      check_bit("hold_rsp_valid", o.rsp_valid, 1'b1);
      check_output("hold_rsp_rdata", o.rsp_rdata, exp_data);
      check_bit("hold_req_ready", o.req_ready, 1'b0);
    end
    drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

    @(negedge clk);
    o = sample(sel);
    check_bit("rsp_valid_cleared", o.rsp_valid, 1'b0);
    check_bit("req_ready_again", o.req_ready, 1'b1);
    drive(sel, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'($urandom));
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear before any edge.
  task automatic reset_between_edges(input string tag);
    obs_t o;
    #2 reset = 1'b1;
    #1 o = sample(0);
    check_bit({tag, "_req_ready"}, o.req_ready, 1'b0);
    check_bit({tag, "_rsp_valid"}, o.rsp_valid, 1'b0);
    check_output({tag, "_rsp_rdata"}, o.rsp_rdata, 16'h0000);
    check_bit({tag, "_rsp_error"}, o.rsp_error, 1'b0);
    #1 reset = 1'b0;
    @(negedge clk);
    o = sample(0);
    check_bit({tag, "_idle_after"}, o.req_ready, 1'b1);
    check_bit({tag, "_no_rsp_after"}, o.rsp_valid, 1'b0);
  endtask

  initial begin
    obs_t        o;
    logic [15:0] addr_a;
    logic [15:0] addr_b;
    int          acc_cycle [$];
    int          pulse_len [$];
    int          run;
    int          pulses;
    bit          switch_pending;
    logic [15:0] a;

    reset = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      o = sample(s[0]);
      check_bit("reset_req_ready", o.req_ready, 1'b0);
      check_bit("reset_rsp_valid", o.rsp_valid, 1'b0);
      check_output("reset_rsp_rdata", o.rsp_rdata, 16'h0000);
      check_bit("reset_rsp_error", o.rsp_error, 1'b0);
    end
    reset = 1'b0;
    @(negedge clk);
    check_bit("idle_ready_l2", sample(0).req_ready, 1'b1);
    check_bit("idle_ready_l1", sample(1).req_ready, 1'b1);

    // Fill both arrays so every later load has a known expected value.
    for (int i = 0; i < DEPTH; i++) begin
      apply_stimulus(0, 1'b1, 16'(i), 16'($urandom), 0);
      apply_stimulus(1, 1'b1, 16'(i), 16'($urandom), 0);
    end
    if (model[0][5] == 16'hAAAA) apply_stimulus(0, 1'b1, 16'h0005, 16'h5555, 0);

    $display("[TB] directed store/load, backpressure, out-of-range");
    apply_stimulus(0, 1'b1, 16'h0010, 16'hBEEF, 0);
    apply_stimulus(0, 1'b0, 16'h0010, 16'h0000, 0);
    apply_stimulus(0, 1'b0, 16'h0010, 16'h0000, 5);
    apply_stimulus(0, 1'b1, 16'h0100, 16'h1234, 0);
    apply_stimulus(0, 1'b0, 16'h0000, 16'h0000, 1);
    apply_stimulus(0, 1'b0, 16'hFFFF, 16'h0000, 2);
    apply_stimulus(0, 1'b1, 16'h00FF, 16'h7E57, 0);
    apply_stimulus(0, 1'b0, 16'h00FF, 16'h0000, 0);

    $display("[TB] reset during BUSY store");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 16'h0005, 16'hAAAA, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
    check_bit("busy_before_reset", sample(0).req_ready, 1'b0);
    reset_between_edges("rst_busy");
    apply_stimulus(0, 1'b0, 16'h0005, 16'h0000, 0);

    $display("[TB] reset during RESP");
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0);
    repeat (LAT2 + 1) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    end
    o = sample(0);
    check_bit("resp_before_reset", o.rsp_valid, 1'b1);
    check_output("resp_data_before_reset", o.rsp_rdata, 16'hBEEF);
    reset_between_edges("rst_resp");

    $display("[TB] LATENCY=1 back-to-back loads");
    addr_a = 16'($urandom_range(0, DEPTH - 1));
    addr_b = 16'($urandom_range(0, DEPTH - 1));
    run = 0;
    pulses = 0;
    switch_pending = 1'b0;
    @(negedge clk);
    drive(1, 1'b1, 1'b0, addr_a, 16'h0000, 1'b1);
    for (int c = 0; c < 12; c++) begin
      if (switch_pending) begin
        switch_pending = 1'b0;
        if (acc_cycle.size() == 1) drive(1, 1'b1, 1'b0, addr_b, 16'h0000, 1'b1);
        else drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
      end
      o = sample(1);
      if (o.rsp_valid) begin
        if (run == 0) begin
          check_output("b2b_rdata", o.rsp_rdata,
                       (pulses == 0) ? model[1][int'(addr_a)] : model[1][int'(addr_b)]);
          pulses++;
        end
        run++;
      end else if (run > 0) begin
        pulse_len.push_back(run);
        run = 0;
      end
      if (o.req_ready && bus1.req_valid) begin
        acc_cycle.push_back(c);
        switch_pending = 1'b1;
      end
      @(negedge clk);
    end
    if (run > 0) pulse_len.push_back(run);
    check_output("b2b_accept_count", 16'(acc_cycle.size()), 16'd2);
    check_output("b2b_pulse_count", 16'(pulse_len.size()), 16'd2);
    // Each cycle spent waiting, one cycle in RESP, then one IDLE cycle since req_ready is low in RESP.
    if (acc_cycle.size() == 2)
      check_output("b2b_accept_spacing", 16'(acc_cycle[1] - acc_cycle[0]), 16'(LAT1 + 2));
    foreach (pulse_len[k]) check_output("b2b_pulse_len", 16'(pulse_len[k]), 16'd1);

    $display("[TB] random traffic");
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(DEPTH, 65535));
      else a = 16'($urandom_range(0, DEPTH - 1));
      apply_stimulus(n[0], 1'($urandom), a, 16'($urandom), $urandom_range(0, 3));
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
